median_filter_5x5: RTL and testbench
====================================

Name: median_filter_5x5

Overview:
- Streaming 5x5 median filter for single-channel video with de/hs/vs timing.
- Holds the four previous lines in line buffers and builds a 5x5 window.
- Outputs the median of the 25 window pixels, plus the window centre pixel as a bypass stream aligned to it.
- Sits in the video pipeline between an upstream pixel source and downstream consumers, such as the image-capture monitor.
- Output resolution is (X-4) x (Y-4).

Parameters:
- LINE_SIZE_MAX, 4096: depth of each line buffer; maximum supported active pixels per line.
- PIXEL_WIDTH, 8: bits per pixel (unsigned).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- bypass  in  1  1: do_o carries the window centre pixel instead of the median.
- di_i  in  PIXEL_WIDTH  input pixel; valid when de_i=1.
- de_i  in  1  input data enable; one pixel per clock with de_i=1; gaps allowed.
- hs_i  in  1  line blanking, active-high; 0 during the active line, 1 between lines.
- vs_i  in  1  frame active, high; 1 during the frame, drops to 0 after the last line.
- do_o  out  PIXEL_WIDTH  filtered pixel (median, or centre when bypass=1).
- de_o  out  1  output data enable.
- hs_o  out  1  hs_i delayed by the pipeline latency.
- vs_o  out  1  vs_i delayed by the pipeline latency.
- bypass_o  out  PIXEL_WIDTH  unfiltered window centre pixel aligned with do_o.

Behaviour:
- Reset (rst=0, asynchronous):
  - do_o, bypass_o, de_o = 0; hs_o = 1; vs_o = 0.
  - Column and line counters and all pipeline valid flags are cleared.
  - Line buffer contents are don't-care.
  - After reset release, de_o stays 0 until vs_i has been sampled low at least once. A mid-frame reset therefore resumes at the next frame.
- Column counter col:
  - Cleared while hs_i=1.
  - Increments on each de_i=1; it is the line buffer address.
- Line counter row:
  - Cleared while vs_i=0.
  - Increments on each hs_i 0->1 edge in a line that contained at least one de_i, saturating at 4095.
- Line buffers: 4 single-port-style RAMs LB0..LB3, LINE_SIZE_MAX x PIXEL_WIDTH. On de_i=1 at address col:
  - Read all four buffers.
  - Write di_i into LB0 and old LBk data into LB(k+1) (cascade).
  - Read-before-write.
- Window:
  - A 5x5 register array shifts one column on each qualified de_i.
  - The new column is {LB3, LB2, LB1, LB0, di_i}, representing lines y-4..y.
  - The centre is the pixel at (x-2, y-2).
- Median arithmetic:
  - Index window pixels p0..p24.
  - rank_i = number of j with p_j < p_i, or p_j == p_i and j < i.
  - Exactly one i has rank 12; its p_i is the median. This is the exact median; ties are safe.
- Pipeline: fixed latency of 4 clk from a de_i sample to the corresponding de_o. The pipeline is free-running; each stage carries a valid bit.
  - Stage 1: window update.
  - Stage 2: 300 pairwise compares registered.
  - Stage 3: rank sums.
  - Stage 4: select and output register.
- de_o = 1 exactly 4 clk after a de_i=1 for which col >= 4 (before increment, i.e. 5th pixel onward) and row >= 4.
- hs_o and vs_o are hs_i and vs_i delayed 4 clk.
- do_o and bypass_o hold their last value when de_o = 0.
- bypass=1: do_o = bypass_o (centre pixel), sampled at stage 1. Latency and de_o are unchanged.
- Per frame of X x Y input: (Y-4) output lines of (X-4) de_o pulses each. Frames with X<5 or Y<5 produce no de_o.
- Lines longer than LINE_SIZE_MAX are unsupported: the address wraps and output is undefined. de_i=1 while hs_i=1 is ignored.
- Input de_i gaps (e.g. 1 or 3 idle clocks per pixel) must not change the output values, only their timing.

Test Plan:
- Constant 16x16 frame, all pixels 100 -> 144 de_o pulses (12 per line, 12 lines); every do_o=100.
- All-zero 16x16 frame with a single 255 at (8,8) -> every do_o=0; bypass_o=255 exactly once.
- 5x5 frame with pixel = x + 5*y (values 0..24) -> exactly one de_o, do_o=12, bypass_o=12.
- bypass=1 on the ramp frame above -> do_o = bypass_o = 12; de_o count unchanged.
- 16x16 random frame repeated with 1 and with 3 idle clocks between pixels -> do_o sequence identical to gapless run. Latency de_i->de_o = 4 clk.
- Assert rst low mid-frame -> outputs go to reset values immediately. No de_o until after the next vs_i low; the following frame is filtered correctly (2-frame run).

Source files
------------

// File: rtl/median_filter_5x5.sv
// -----------------------------------------------------------------------------
// median_filter_5x5
//
// Streaming 5x5 median filter for single-channel video carried with de/hs/vs
// timing. Four line buffers hold the previous lines. Together with the incoming
// pixel they form a 5x5 sliding window. The filter outputs the exact median of
// the 25 window pixels. The window centre pixel is output alongside it as a
// bypass stream.
//
// The pipeline has a fixed latency of 4 clocks from a de_i sample to de_o:
//   stage 1  window shift (line buffer data is prefetched, so it is ready)
//   stage 2  300 pairwise compares registered
//   stage 3  rank sums for all 25 pixels
//   stage 4  pick the pixel of rank 12, output register
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   bypass    1: do_o carries the window centre instead of the median
//   di_i      input pixel, valid while de_i=1
//   de_i      input data enable (gaps allowed)
//   hs_i      line blanking, 1 between lines
//   vs_i      frame active, 0 between frames
//   do_o      filtered pixel (median, or centre in bypass mode)
//   de_o      output data enable
//   hs_o      hs_i delayed by 4 clocks
//   vs_o      vs_i delayed by 4 clocks
//   bypass_o  unfiltered window centre aligned with do_o
// -----------------------------------------------------------------------------
module median_filter_5x5 #(
  parameter int LINE_SIZE_MAX = 4096,
  parameter int PIXEL_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bypass,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic [PIXEL_WIDTH-1:0] bypass_o
);

  localparam int AW    = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;
  localparam int NPIX  = 25;
  localparam int NPAIR = NPIX * (NPIX - 1) / 2;
  localparam int RW    = 5;

  // A pixel counts only during the active part of a line.
  logic pix_en;
  assign pix_en = de_i & ~hs_i;

  // ---------------------------------------------------------------------------
  // Column / line counters and frame arming
  // ---------------------------------------------------------------------------
  logic [AW-1:0] col_reg, col_next;
  logic [11:0]   row_reg, row_next;
  logic          hs_prev_reg;
  logic          line_has_de_reg, line_has_de_next;
  logic          armed_reg;

  always_comb begin
    col_next = col_reg;
    if (hs_i) begin
      col_next = '0;
    end else if (pix_en) begin
      col_next = col_reg + AW'(1);
    end
  end

  always_comb begin
    row_next         = row_reg;
    line_has_de_next = line_has_de_reg;
    if (pix_en) begin
      line_has_de_next = 1'b1;
    end
    // A blanking edge closes a line. Empty lines are not counted.
    if (hs_i && !hs_prev_reg) begin
      line_has_de_next = 1'b0;
      if (line_has_de_reg && (row_reg != 12'hFFF)) begin
        row_next = row_reg + 12'd1;
      end
    end
    if (!vs_i) begin
      row_next         = '0;
      line_has_de_next = 1'b0;
    end
  end

  // armed_reg holds output off until a frame boundary has been seen. After a
  // reset mid-frame, the partial frame therefore produces no output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg         <= '0;
      row_reg         <= '0;
      hs_prev_reg     <= 1'b1;
      line_has_de_reg <= 1'b0;
      armed_reg       <= 1'b0;
    end else begin
      col_reg         <= col_next;
      row_reg         <= row_next;
      hs_prev_reg     <= hs_i;
      line_has_de_reg <= line_has_de_next;
      armed_reg       <= armed_reg | ~vs_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers LB0..LB3, cascaded
  // The read port always fetches the address that col will hold after this
  // edge. When a pixel arrives, its column is therefore already in rd_reg.
  // That old value is written into the next buffer in the same cycle, which
  // gives read-before-write behaviour without a same-address conflict.
  // ---------------------------------------------------------------------------
  logic [3:0][PIXEL_WIDTH-1:0] lb_rd;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lb
      logic [PIXEL_WIDTH-1:0] mem [LINE_SIZE_MAX];
      logic [PIXEL_WIDTH-1:0] rd_reg;
      logic [PIXEL_WIDTH-1:0] wr_data;

      if (gi == 0) begin : g_head
        assign wr_data = di_i;
      end else begin : g_tail
        assign wr_data = lb_rd[gi-1];
      end

      always_ff @(posedge clk) begin
        if (pix_en) begin
          mem[col_reg] <= wr_data;
        end
        rd_reg <= mem[col_next];
      end

      assign lb_rd[gi] = rd_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 1: 5x5 window. Pixel index is row*5 + col. Row 0 is line y-4 and
  // row 4 is the current line. Column 4 is the newest pixel. Index 12 is the
  // centre, at (x-2, y-2).
  // ---------------------------------------------------------------------------
  logic [4:0][PIXEL_WIDTH-1:0]      new_col;
  logic [NPIX-1:0][PIXEL_WIDTH-1:0] win_reg;
  logic                             v1_reg, byp1_reg;

  assign new_col[4] = di_i;
  assign new_col[3] = lb_rd[0];
  assign new_col[2] = lb_rd[1];
  assign new_col[1] = lb_rd[2];
  assign new_col[0] = lb_rd[3];

  always_ff @(posedge clk) begin
    if (pix_en) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_reg[r*5+c] <= win_reg[r*5+c+1];
        end
        win_reg[r*5+4] <= new_col[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: pairwise compares. There is one bit per pair (i<j):
  //   gt = (p_j < p_i)
  // If the bit is set, j adds to rank_i. Otherwise i adds to rank_j. The
  // second case covers equal values, where i wins by its lower index. This
  // tie rule gives every pixel a distinct rank, so exactly one pixel has
  // rank 12.
  // ---------------------------------------------------------------------------
  logic [NPAIR-1:0]                 gt_next, gt_reg;
  logic [NPIX-1:0][PIXEL_WIDTH-1:0] pix2_reg;
  logic [PIXEL_WIDTH-1:0]           ctr2_reg;
  logic                             v2_reg, byp2_reg;

  generate
    for (gi = 0; gi < NPIX - 1; gi++) begin : g_cmp_i
      for (gj = gi + 1; gj < NPIX; gj++) begin : g_cmp_j
        localparam int K = gi * (2 * NPIX - 1 - gi) / 2 + (gj - gi - 1);
        assign gt_next[K] = (win_reg[gj] < win_reg[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    gt_reg   <= gt_next;
    pix2_reg <= win_reg;
    ctr2_reg <= win_reg[12];
  end

  // ---------------------------------------------------------------------------
  // Stage 3: rank sums. The pair bits are walked in the same order in which
  // they were packed.
  // ---------------------------------------------------------------------------
  logic [NPIX-1:0][RW-1:0]          rank_next, rank_reg;
  logic [8:0]                       pair_k;
  logic [NPIX-1:0][PIXEL_WIDTH-1:0] pix3_reg;
  logic [PIXEL_WIDTH-1:0]           ctr3_reg;
  logic                             v3_reg, byp3_reg;

  always_comb begin
    rank_next = '0;
    pair_k    = '0;
    for (int i = 0; i < NPIX - 1; i++) begin
      for (int j = i + 1; j < NPIX; j++) begin
        if (gt_reg[pair_k]) begin
          rank_next[i] = rank_next[i] + RW'(1);
        end else begin
          rank_next[j] = rank_next[j] + RW'(1);
        end
        pair_k = pair_k + 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    rank_reg <= rank_next;
    pix3_reg <= pix2_reg;
    ctr3_reg <= ctr2_reg;
  end

  // ---------------------------------------------------------------------------
  // Stage 4: select the rank-12 pixel. Only one rank matches, so an OR
  // reduction acts as the mux.
  // ---------------------------------------------------------------------------
  logic [PIXEL_WIDTH-1:0] med_sel;

  always_comb begin
    med_sel = '0;
    for (int i = 0; i < NPIX; i++) begin
      if (rank_reg[i] == RW'(12)) begin
        med_sel = med_sel | pix3_reg[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control pipeline: valid flags, bypass select, sync delays, outputs
  // ---------------------------------------------------------------------------
  logic [3:0] hs_pipe_reg, vs_pipe_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      v3_reg      <= 1'b0;
      byp1_reg    <= 1'b0;
      byp2_reg    <= 1'b0;
      byp3_reg    <= 1'b0;
      hs_pipe_reg <= '1;
      vs_pipe_reg <= '0;
      de_o        <= 1'b0;
      do_o        <= '0;
      bypass_o    <= '0;
    end else begin
      v1_reg      <= pix_en & armed_reg & (col_reg >= AW'(4)) & (row_reg >= 12'd4);
      v2_reg      <= v1_reg;
      v3_reg      <= v2_reg;
      byp1_reg    <= bypass;
      byp2_reg    <= byp1_reg;
      byp3_reg    <= byp2_reg;
      hs_pipe_reg <= {hs_pipe_reg[2:0], hs_i};
      vs_pipe_reg <= {vs_pipe_reg[2:0], vs_i};
      de_o        <= v3_reg;
      // Outputs hold their last value between valid pixels.
      if (v3_reg) begin
        bypass_o <= ctr3_reg;
        do_o     <= byp3_reg ? ctr3_reg : med_sel;
      end
    end
  end

  assign hs_o = hs_pipe_reg[3];
  assign vs_o = vs_pipe_reg[3];

endmodule

// File: tb/tb_median_filter_5x5.sv
// -----------------------------------------------------------------------------
// tb_median_filter_5x5
//
// Self-checking bench for median_filter_5x5. Each table record describes a
// frame: pattern, size, idle gap and bypass mode, plus fixed expected values.
// Every output is also checked against a reference. The reference sorts the
// 25 window pixels and takes element 12; the centre pixel is read directly
// from the stored frame. A hand-written sequence covers reset mid-frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_median_filter_5x5;

  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bypass = 1'b0;
  logic [PW-1:0] di_i = '0;
  logic          de_i = 1'b0;
  logic          hs_i = 1'b1;
  logic          vs_i = 1'b0;
  logic [PW-1:0] do_o;
  logic          de_o;
  logic          hs_o;
  logic          vs_o;
  logic [PW-1:0] bypass_o;

  median_filter_5x5 #(.LINE_SIZE_MAX(64), .PIXEL_WIDTH(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bypass   (bypass),
    .di_i     (di_i),
    .de_i     (de_i),
    .hs_i     (hs_i),
    .vs_i     (vs_i),
    .do_o     (do_o),
    .de_o     (de_o),
    .hs_o     (hs_o),
    .vs_o     (vs_o),
    .bypass_o (bypass_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Output capture, sampled on the falling edge.
  int out_do[$];
  int out_bp[$];
  int out_cyc[$];
  int lat_q[$];   // cycle in which each qualifying de_i was driven

  always @(negedge clk) begin
    if (de_o) begin
      out_do.push_back(int'(do_o));
      out_bp.push_back(int'(bypass_o));
      out_cyc.push_back(cyc);
    end
  end

  // hs_o/vs_o must equal hs_i/vs_i from four cycles earlier. The check is
  // skipped until 5 reset-free cycles have passed.
  logic [1:0] hv_hist [8];
  int         hv_arm = 0;
  always @(negedge clk) begin
    if (!rst) hv_arm = 0;
    else if (hv_arm < 5) hv_arm++;
    if (hv_arm >= 5) begin
      check("hs_o_delay", int'(hs_o), int'(hv_hist[(cyc - 4) & 7][1]));
      check("vs_o_delay", int'(vs_o), int'(hv_hist[(cyc - 4) & 7][0]));
    end
    hv_hist[cyc & 7] = {hs_i, vs_i};
  end

  // Frame store and reference results.
  int frame [256];
  int exp_med[$];
  int exp_ctr[$];
  int saved_seq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build(input int pat, input int xs, input int ys);
    for (int y = 0; y < ys; y++) begin
      for (int x = 0; x < xs; x++) begin
        case (pat)
          0: frame[y*xs+x] = 100;
          1: frame[y*xs+x] = (x == 8 && y == 8) ? 255 : 0;
          2: frame[y*xs+x] = (x + 5*y) & 255;
          3: frame[y*xs+x] = int'($urandom_range(0, 255));
          default: ;  // reuse the previous frame
        endcase
      end
    end
  endtask

  task automatic model(input int xs, input int ys);
    int w[$];
    exp_med.delete();
    exp_ctr.delete();
    for (int y = 4; y < ys; y++) begin
      for (int x = 4; x < xs; x++) begin
        w.delete();
        for (int dy = 0; dy < 5; dy++)
          for (int dx = 0; dx < 5; dx++)
            w.push_back(frame[(y-4+dy)*xs + (x-4+dx)]);
        w.sort();
        exp_med.push_back(w[12]);
        exp_ctr.push_back(frame[(y-2)*xs + (x-2)]);
      end
    end
  endtask

  // Drives one frame: vertical blanking first, then lines separated by
  // horizontal blanking. rst_line >= 0 pulses reset in that line.
  task automatic drive_frame(input int xs, input int ys, input int gap, input int rst_line);
    bit dead = 1'b0;
    vs_i = 1'b0; hs_i = 1'b1; de_i = 1'b0;
    repeat (4) tick();
    vs_i = 1'b1;
    for (int y = 0; y < ys; y++) begin
      hs_i = 1'b1; de_i = 1'b0;
      repeat (3) tick();
      hs_i = 1'b0;
      for (int x = 0; x < xs; x++) begin
        if (y == rst_line && x == 6) begin
          #2 rst = 1'b0;
          #1;
          check("rst_do_o", int'(do_o), 0);
          check("rst_bypass_o", int'(bypass_o), 0);
          check("rst_de_o", int'(de_o), 0);
          check("rst_hs_o", int'(hs_o), 1);
          check("rst_vs_o", int'(vs_o), 0);
          out_do.delete(); out_bp.delete(); out_cyc.delete(); lat_q.delete();
          dead = 1'b1;
        end
        if (y == rst_line && x == 9) rst = 1'b1;
        di_i = PW'(frame[y*xs+x]);
        de_i = 1'b1;
        if (!dead && x >= 4 && y >= 4) lat_q.push_back(cyc);
        tick();
        de_i = 1'b0;
        repeat (gap) tick();
      end
    end
    hs_i = 1'b1; de_i = 1'b0;
    repeat (3) tick();
    vs_i = 1'b0;
    repeat (10) tick();
  endtask

  task automatic clear_capture();
    out_do.delete(); out_bp.delete(); out_cyc.delete(); lat_q.delete();
  endtask

  // Compares the captured outputs against the reference.
  task automatic compare_outputs(input bit byp, input string tag);
    int n;
    n = out_do.size();
    check({tag, "_count_vs_model"}, n, exp_med.size());
    for (int k = 0; k < n && k < exp_med.size(); k++) begin
      check($sformatf("%s_do[%0d]", tag, k), out_do[k], byp ? exp_ctr[k] : exp_med[k]);
      check($sformatf("%s_bypass_o[%0d]", tag, k), out_bp[k], exp_ctr[k]);
      if (k < lat_q.size())
        check($sformatf("%s_latency[%0d]", tag, k), out_cyc[k] - lat_q[k], 4);
    end
  endtask

  typedef struct {
    int pat;        // 0 const 100, 1 impulse, 2 ramp, 3 new random, 4 reuse
    int xs;
    int ys;
    int gap;        // idle clocks after each pixel
    bit byp;
    int exp_count;  // expected de_o pulses
    int exp_do;     // fixed do_o value, -1 = none
    int exp_bp;     // fixed bypass_o value, -1 = none
    int exp_hits;   // number of bypass_o == 255, -1 = skip
    int seq;        // 1 save do_o sequence, 2 compare with saved
  } rec_t;

  rec_t recs [10];

  initial begin
    recs[0] = '{0, 16, 16, 0, 1'b0, 144, 100, 100,  0, 0};
    recs[1] = '{1, 16, 16, 0, 1'b0, 144,   0,  -1,  1, 0};
    recs[2] = '{2,  5,  5, 0, 1'b0,   1,  12,  12,  0, 0};
    recs[3] = '{2,  5,  5, 0, 1'b1,   1,  12,  12,  0, 0};
    recs[4] = '{2,  4,  5, 0, 1'b0,   0,  -1,  -1,  0, 0};
    recs[5] = '{2,  5,  4, 0, 1'b0,   0,  -1,  -1,  0, 0};
    recs[6] = '{3, 16, 16, 0, 1'b0, 144,  -1,  -1, -1, 1};
    recs[7] = '{4, 16, 16, 1, 1'b0, 144,  -1,  -1, -1, 2};
    recs[8] = '{4, 16, 16, 3, 1'b0, 144,  -1,  -1, -1, 2};
    recs[9] = '{3,  9,  7, 2, 1'b1,  15,  -1,  -1, -1, 0};

    // Reset state
    repeat (3) tick();
    check("reset_do_o", int'(do_o), 0);
    check("reset_bypass_o", int'(bypass_o), 0);
    check("reset_de_o", int'(de_o), 0);
    check("reset_hs_o", int'(hs_o), 1);
    check("reset_vs_o", int'(vs_o), 0);
    rst = 1'b1;
    repeat (2) tick();

    for (int r = 0; r < 10; r++) begin
      int hits;
      build(recs[r].pat, recs[r].xs, recs[r].ys);
      model(recs[r].xs, recs[r].ys);
      bypass = recs[r].byp;
      clear_capture();
      drive_frame(recs[r].xs, recs[r].ys, recs[r].gap, -1);
      $display("vec %0d: pat=%0d size=%0dx%0d gap=%0d bypass=%0d outputs=%0d",
               r, recs[r].pat, recs[r].xs, recs[r].ys, recs[r].gap, recs[r].byp, out_do.size());
      check($sformatf("vec%0d_count", r), out_do.size(), recs[r].exp_count);
      compare_outputs(recs[r].byp, $sformatf("vec%0d", r));
      hits = 0;
      for (int k = 0; k < out_do.size(); k++) begin
        if (recs[r].exp_do >= 0) check($sformatf("vec%0d_do_const[%0d]", r, k), out_do[k], recs[r].exp_do);
        if (recs[r].exp_bp >= 0) check($sformatf("vec%0d_bp_const[%0d]", r, k), out_bp[k], recs[r].exp_bp);
        if (out_bp[k] == 255) hits++;
      end
      if (recs[r].exp_hits >= 0) check($sformatf("vec%0d_bp255_hits", r), hits, recs[r].exp_hits);
      if (recs[r].seq == 1) saved_seq = out_do;
      if (recs[r].seq == 2) begin
        check($sformatf("vec%0d_gap_seq_len", r), out_do.size(), saved_seq.size());
        for (int k = 0; k < out_do.size() && k < saved_seq.size(); k++)
          check($sformatf("vec%0d_gap_seq[%0d]", r, k), out_do[k], saved_seq[k]);
      end
    end

    // Reset in the middle of a frame, then one clean frame.
    bypass = 1'b0;
    build(3, 16, 16);
    clear_capture();
    drive_frame(16, 16, 0, 8);
    $display("midreset frame: outputs after reset=%0d", out_do.size());
    check("midreset_no_de_o", out_do.size(), 0);

    build(3, 16, 16);
    model(16, 16);
    clear_capture();
    drive_frame(16, 16, 0, -1);
    $display("post-reset frame: outputs=%0d", out_do.size());
    check("postreset_count", out_do.size(), 144);
    compare_outputs(1'b0, "postreset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
